// File: rtl/wb_stage.sv
// DLX writeback stage: drives the register-file write port from
// retiring ALU results and completed (byte/half/word) loads.
module wb_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_wen,
    input  logic             mem_is_load,
    input  logic [2:0]       mem_load_type,
    input  logic [1:0]       mem_addr_lo,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_alu_res,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             stall,
    output logic [4:0]       Rd,
    output logic [31:0]      reg_s,
    output logic             reg_s_enable,
    output logic             proto_err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    localparam logic [2:0] LT_B  = 3'b000;
    localparam logic [2:0] LT_H  = 3'b001;
    localparam logic [2:0] LT_W  = 3'b010;
    localparam logic [2:0] LT_BU = 3'b100;
    localparam logic [2:0] LT_HU = 3'b101;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    logic [0:0]    state;
    logic [TW-1:0] cnt;
    logic [4:0]    ld_rd;
    logic          ld_wen;
    logic [2:0]    ld_type;
    logic [1:0]    ld_lo;

    logic          load_ok;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ext_v;

    assign stall = (state == WAIT_LOAD);

    always_comb begin
        load_ok = 1'b0;
        unique case (mem_load_type)
            LT_B, LT_BU: load_ok = 1'b1;
            LT_H, LT_HU: load_ok = ~mem_addr_lo[0];
            LT_W:        load_ok = (mem_addr_lo == 2'b00);
            default:     load_ok = 1'b0;
        endcase
    end

    // Big-endian: byte 0 lives in the most significant lane.
    always_comb begin
        byte_v = dmem_rdata[31:24];
        unique case (ld_lo)
            2'd0: byte_v = dmem_rdata[31:24];
            2'd1: byte_v = dmem_rdata[23:16];
            2'd2: byte_v = dmem_rdata[15:8];
            2'd3: byte_v = dmem_rdata[7:0];
            default: byte_v = dmem_rdata[31:24];
        endcase
        half_v = ld_lo[1] ? dmem_rdata[15:0]
                          : dmem_rdata[31:16];
    end

    always_comb begin
        ext_v = dmem_rdata;
        unique case (ld_type)
            LT_B:    ext_v = {{24{byte_v[7]}}, byte_v};
            LT_BU:   ext_v = {24'b0, byte_v};
            LT_H:    ext_v = {{16{half_v[15]}}, half_v};
            LT_HU:   ext_v = {16'b0, half_v};
            default: ext_v = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_rd        <= '0;
            ld_wen       <= 1'b0;
            ld_type      <= '0;
            ld_lo        <= '0;
            Rd           <= '0;
            reg_s        <= '0;
            reg_s_enable <= 1'b0;
            proto_err    <= 1'b0;
            retired      <= '0;
        end else begin
            reg_s_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_valid) begin
                        retired <= retired + CNT_W'(1);
                        if (!mem_is_load) begin
                            if (mem_wen && mem_rd != 5'd0) begin
                                reg_s_enable <= 1'b1;
                                Rd           <= mem_rd;
                                reg_s        <= mem_alu_res;
                            end
                        end else if (load_ok) begin
                            state   <= WAIT_LOAD;
                            cnt     <= '0;
                            ld_rd   <= mem_rd;
                            ld_wen  <= mem_wen;
                            ld_type <= mem_load_type;
                            ld_lo   <= mem_addr_lo;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                WAIT_LOAD: begin
                    // A response in the last allowed cycle beats the timeout.
                    if (dmem_rvalid) begin
                        state <= IDLE;
                        if (ld_wen && ld_rd != 5'd0) begin
                            reg_s_enable <= 1'b1;
                            Rd           <= ld_rd;
                            reg_s        <= ext_v;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        proto_err <= 1'b1;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by
// random traffic, all checked against a transaction-level model.
module tb_wb_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_wen;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_res;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [4:0]  Rd;
    logic [31:0] reg_s;
    logic        reg_s_enable;
    logic        proto_err;
    logic [31:0] retired;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_known = 0;
    bit          m_busy  = 0;
    bit          m_err   = 0;
    int unsigned m_ret   = 0;
    int          m_wait  = 0;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [2:0]  m_type;
    logic [1:0]  m_lo;
    bit          exp_en  = 0;
    logic [4:0]  exp_rd  = '0;
    logic [31:0] exp_s   = '0;

    always #5 clk = ~clk;

    wb_stage #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_valid     (mem_valid),
        .mem_wen       (mem_wen),
        .mem_is_load   (mem_is_load),
        .mem_load_type (mem_load_type),
        .mem_addr_lo   (mem_addr_lo),
        .mem_rd        (mem_rd),
        .mem_alu_res   (mem_alu_res),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .stall         (stall),
        .Rd            (Rd),
        .reg_s         (reg_s),
        .reg_s_enable  (reg_s_enable),
        .proto_err     (proto_err),
        .retired       (retired)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h",
                     tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] t,
                                 input logic [1:0] lo);
        int ti = int'(t);
        int li = int'(lo);
        if (ti == 0 || ti == 4) return 1;
        if (ti == 1 || ti == 5) return (li % 2) == 0;
        if (ti == 2) return li == 0;
        return 0;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] t,
                                        input logic [1:0] lo,
                                        input logic [31:0] d);
        int unsigned v;
        int ti = int'(t);
        int li = int'(lo);
        if (ti == 0 || ti == 4) begin
            v = (d >> (8 * (3 - li))) & 32'hFF;
            if (ti == 0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (ti == 1 || ti == 5) begin
            v = (d >> ((li >= 2) ? 0 : 16)) & 32'hFFFF;
            if (ti == 1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic model_step();
        exp_en = 0;
        if (reset) begin
            m_busy = 0; m_err = 0; m_ret = 0; m_wait = 0;
            exp_rd = '0; exp_s = '0;
        end else if (!m_busy) begin
            if (mem_valid) begin
                m_ret++;
                if (!mem_is_load) begin
                    if (mem_wen && mem_rd != 0) begin
                        exp_en = 1;
                        exp_rd = mem_rd;
                        exp_s  = mem_alu_res;
                    end
                end else if (legal(mem_load_type, mem_addr_lo)) begin
                    m_busy = 1; m_wait = 0;
                    m_wen  = mem_wen; m_rd = mem_rd;
                    m_type = mem_load_type; m_lo = mem_addr_lo;
                end else begin
                    m_err = 1;
                end
            end
        end else if (dmem_rvalid) begin
            m_busy = 0;
            if (m_wen && m_rd != 0) begin
                exp_en = 1;
                exp_rd = m_rd;
                exp_s  = ext(m_type, m_lo, dmem_rdata);
            end
        end else begin
            m_wait++;
            if (m_wait == TO) begin
                m_busy = 0;
                m_err  = 1;
            end
        end
    endtask

    // Inputs are set after a negedge; one call covers one clock.
    task automatic cycle();
        #1;
        if (m_known) chk("stall", stall, m_busy);
        model_step();
        @(posedge clk);
        #1;
        m_known = 1;
        chk("enable", reg_s_enable, exp_en);
        chk("proto_err", proto_err, m_err);
        chk("retired", retired, m_ret);
        chk("Rd", Rd, exp_rd);
        chk("reg_s", reg_s, exp_s);
        @(negedge clk);
    endtask

    task automatic idle_in();
        reset = 0; mem_valid = 0; mem_wen = 0; mem_is_load = 0;
        mem_load_type = 0; mem_addr_lo = 0; mem_rd = 0;
        mem_alu_res = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_in(); reset = 1; cycle(); reset = 0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] v);
        idle_in();
        mem_valid = 1; mem_wen = 1; mem_rd = rd; mem_alu_res = v;
        cycle();
        idle_in();
    endtask

    task automatic ld_issue(input logic [2:0] t, input logic [1:0] lo,
                            input logic [4:0] rd);
        idle_in();
        mem_valid = 1; mem_wen = 1; mem_is_load = 1;
        mem_load_type = t; mem_addr_lo = lo; mem_rd = rd;
        cycle();
        idle_in();
    endtask

    task automatic do_load(input logic [2:0] t, input logic [1:0] lo,
                           input logic [4:0] rd, input int dly,
                           input logic [31:0] d);
        int st = 0;
        ld_issue(t, lo, rd);
        for (int i = 1; i < dly; i++) begin
            st += int'(stall); cycle();
        end
        st += int'(stall);
        dmem_rvalid = 1; dmem_rdata = d;
        cycle();
        idle_in();
        chk("load_stall_cycles", st, dly);
    endtask

    initial begin
        int st;
        idle_in();
        @(negedge clk);
        do_reset();
        chk("rst_retired", retired, 0);
        chk("rst_enable", reg_s_enable, 0);
        chk("rst_stall", stall, 0);

        alu(5'd5, 32'hDEAD_BEEF);
        chk("alu_en", reg_s_enable, 1);
        chk("alu_rd", Rd, 5);
        chk("alu_val", reg_s, 32'hDEAD_BEEF);
        cycle();
        chk("alu_en_drop", reg_s_enable, 0);
        chk("alu_retired", retired, 1);

        alu(5'd0, 32'h1234);
        chk("rd0_en", reg_s_enable, 0);
        chk("rd0_retired", retired, 2);

        do_load(3'b000, 2'd1, 5'd3, 3, 32'h11F2_3344);
        chk("lb_rd", Rd, 3);
        chk("lb_val", reg_s, 32'hFFFF_FFF2);
        do_load(3'b100, 2'd1, 5'd3, 3, 32'h11F2_3344);
        chk("lbu_val", reg_s, 32'h0000_00F2);
        do_load(3'b001, 2'd2, 5'd4, 2, 32'h11F2_3344);
        chk("lh_val", reg_s, 32'h0000_3344);
        do_load(3'b101, 2'd0, 5'd6, 1, 32'h8001_5678);
        chk("lhu_val", reg_s, 32'h0000_8001);

        ld_issue(3'b010, 2'd2, 5'd8);
        chk("lw_mis_err", proto_err, 1);
        chk("lw_mis_stall", stall, 0);
        chk("lw_mis_en", reg_s_enable, 0);
        do_reset();
        ld_issue(3'b011, 2'd0, 5'd8);
        chk("bad_type_err", proto_err, 1);
        chk("bad_type_stall", stall, 0);

        do_reset();
        ld_issue(3'b010, 2'd0, 5'd9);
        st = 0;
        for (int i = 0; i < TO; i++) begin
            st += int'(stall); cycle();
        end
        chk("to_stall_cycles", st, TO);
        chk("to_err", proto_err, 1);
        chk("to_stall_low", stall, 0);
        dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
        cycle();
        idle_in();
        chk("late_rvalid_en", reg_s_enable, 0);

        do_reset();
        ld_issue(3'b010, 2'd0, 5'd10);
        cycle();
        do_reset();
        dmem_rvalid = 1; dmem_rdata = 32'h0BAD_0BAD;
        cycle();
        idle_in();
        chk("rst_mid_en", reg_s_enable, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_err", proto_err, 0);
        chk("rst_mid_ret", retired, 0);

        ld_issue(3'b010, 2'd0, 5'd7);
        dmem_rvalid = 1; dmem_rdata = 32'h1357_9BDF;
        cycle();
        chk("b2b_ld_en", reg_s_enable, 1);
        chk("b2b_ld_rd", Rd, 7);
        chk("b2b_ld_val", reg_s, 32'h1357_9BDF);
        alu(5'd9, 32'h2468_ACE0);
        chk("b2b_alu_en", reg_s_enable, 1);
        chk("b2b_alu_rd", Rd, 9);
        chk("b2b_alu_val", reg_s, 32'h2468_ACE0);

        for (int i = 0; i < 4000; i++) begin
            if (!m_busy) begin
                mem_valid   = ($urandom % 3) != 0;
                mem_wen     = ($urandom % 4) != 0;
                mem_is_load = ($urandom % 2) != 0;
                mem_load_type = ($urandom % 6 == 0) ?
                    3'($urandom) : 3'(($urandom % 2) * 4
                                      + $urandom % 3);
                mem_addr_lo = 2'($urandom);
                mem_rd      = 5'($urandom);
                mem_alu_res = $urandom;
            end
            dmem_rvalid = ($urandom % 4) == 0;
            dmem_rdata  = $urandom;
            reset       = ($urandom % 150) == 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
